// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge stage.
package sobel_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned PIX_W_DEF    = 10;
    localparam int unsigned GRAD_W       = 13;
    localparam int unsigned MAG_W        = 13;
    localparam int unsigned ROW_W        = 11;
    localparam logic [9:0]  PIX_MAX      = 10'd1023;

    typedef logic [9:0]                pix_t;
    typedef logic signed [GRAD_W-1:0]  grad_t;
    typedef logic [MAG_W-1:0]          mag_t;

    // Gradients stay within +/-4092, so negation never overflows.
    function automatic mag_t abs_grad(input grad_t g);
        return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
    endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// Single-port-address line buffer: one write and one read per cycle, read returns old data.
module sobel_line_ram #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read sees the contents before this cycle's write lands.
    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_edge_detect.sv
// 3x3 Sobel edge stage: line buffers, window, col/row tracking and a two-stage
// gradient/magnitude pipeline with border suppression and optional thresholding.
module sobel_edge_detect
    import sobel_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter int unsigned MAG_SHIFT = 2
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSOF,
    input  logic             iDVAL,
    input  logic [PIX_W-1:0] iGRAY,
    input  logic             iMODE,
    input  logic [PIX_W-1:0] iTHRESH,
    output logic [PIX_W-1:0] oEDGE,
    output logic             oDVAL
);

    localparam int unsigned      COL_W    = $clog2(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;
    localparam logic [PIX_W-1:0] EDGE_MAX = '1;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] cap_col;
    logic [ROW_W-1:0] cap_row;

    logic [PIX_W-1:0] tap_row1;
    logic [PIX_W-1:0] tap_row2;

    logic [PIX_W-1:0] win_q [3][3];
    logic             v1_q;
    logic             k1_q;

    grad_t            gx;
    grad_t            gy;
    grad_t            gx_q;
    grad_t            gy_q;
    logic             v2_q;
    logic             k2_q;

    mag_t             mag;
    mag_t             mag_s;
    logic [PIX_W-1:0] edge_val;

    // A start-of-frame pulse takes effect before a coincident pixel is placed.
    always_comb begin
        cap_col = iSOF ? '0 : col_q;
        cap_row = iSOF ? '0 : row_q;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            col_q <= '0;
            row_q <= '0;
        end else if (iDVAL) begin
            if (cap_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (cap_row == ROW_MAX) ? cap_row : cap_row + 1'b1;
            end else begin
                col_q <= cap_col + 1'b1;
                row_q <= cap_row;
            end
        end else if (iSOF) begin
            col_q <= '0;
            row_q <= '0;
        end
    end

    sobel_line_ram #(
        .DEPTH (H_ACTIVE),
        .WIDTH (PIX_W),
        .ADDR_W(COL_W)
    ) u_lb0 (
        .clk  (iCLK),
        .we   (iDVAL),
        .addr (cap_col),
        .wdata(iGRAY),
        .rdata(tap_row1)
    );

    sobel_line_ram #(
        .DEPTH (H_ACTIVE),
        .WIDTH (PIX_W),
        .ADDR_W(COL_W)
    ) u_lb1 (
        .clk  (iCLK),
        .we   (iDVAL),
        .addr (cap_col),
        .wdata(tap_row1),
        .rdata(tap_row2)
    );

    // Window rows: 0 = two lines up, 2 = current line; column 2 is the newest pixel.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            v1_q <= 1'b0;
            k1_q <= 1'b0;
        end else begin
            v1_q <= iDVAL;
            if (iDVAL) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= tap_row2;
                win_q[1][2] <= tap_row1;
                win_q[2][2] <= iGRAY;
                k1_q        <= (cap_col < COL_W'(2)) || (cap_row < ROW_W'(2));
            end
        end
    end

    function automatic grad_t ext(input logic [PIX_W-1:0] p);
        return grad_t'(p);
    endfunction

    always_comb begin
        gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            gx_q <= '0;
            gy_q <= '0;
            v2_q <= 1'b0;
            k2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                gx_q <= gx;
                gy_q <= gy;
                k2_q <= k1_q;
            end
        end
    end

    always_comb begin
        mag   = abs_grad(gx_q) + abs_grad(gy_q);
        mag_s = mag >> MAG_SHIFT;
        if (k2_q) begin
            edge_val = '0;
        end else if (iMODE) begin
            edge_val = (mag_s >= MAG_W'(iTHRESH)) ? EDGE_MAX : '0;
        end else if (mag_s > MAG_W'(EDGE_MAX)) begin
            edge_val = EDGE_MAX;
        end else begin
            edge_val = mag_s[PIX_W-1:0];
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oEDGE <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDVAL <= v2_q;
            if (v2_q) begin
                oEDGE <= edge_val;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Scoreboard bench for sobel_edge_detect: a 2D image model predicts each output and its arrival cycle.
module tb_sobel_edge_detect;

    localparam int H = 640;

    logic       iCLK;
    logic       iRST_N;
    logic       iSOF;
    logic       iDVAL;
    logic [9:0] iGRAY;
    logic       iMODE;
    logic [9:0] iTHRESH;
    logic [9:0] oEDGE;
    logic       oDVAL;

    sobel_edge_detect #(
        .H_ACTIVE (640),
        .PIX_W    (10),
        .MAG_SHIFT(2)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iSOF   (iSOF),
        .iDVAL  (iDVAL),
        .iGRAY  (iGRAY),
        .iMODE  (iMODE),
        .iTHRESH(iTHRESH),
        .oEDGE  (oEDGE),
        .oDVAL  (oDVAL)
    );

    typedef struct {
        int edge_v;
        int due;
        int col;
        int row;
    } sb_t;

    sb_t sb_q[$];
    int  img[4][H];
    int  m_col;
    int  m_row;
    int  cur_mode;
    int  cur_thresh;
    int  cyc;
    int  n_cmp;
    int  n_err;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_edge(input int c, input int r);
        int p[3][3];
        int gx, gy, mag, s;
        if (c < 2 || r < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[(r - 2 + i) % 4][c - 2 + j];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        s = mag >> 2;
        if (cur_mode != 0) return (s >= cur_thresh) ? 1023 : 0;
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic drive_pix(input int g, input logic sof);
        sb_t e;
        @(posedge iCLK);
        #1;
        iDVAL = 1'b1;
        iSOF  = sof;
        iGRAY = 10'(g);
        if (sof) begin
            m_col = 0;
            m_row = 0;
        end
        img[m_row % 4][m_col] = g;
        e.edge_v = model_edge(m_col, m_row);
        e.due    = cyc + 3;
        e.col    = m_col;
        e.row    = m_row;
        sb_q.push_back(e);
        if (m_col == H - 1) begin
            m_col = 0;
            if (m_row < 2047) m_row++;
        end else begin
            m_col++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
            iDVAL = 1'b0;
            iSOF  = 1'b0;
        end
    endtask

    // Every output pulse must match the oldest prediction and arrive on its due cycle.
    always @(negedge iCLK) begin
        sb_t e;
        if (iRST_N && oDVAL) begin
            if (sb_q.size() == 0) begin
                check("spurious_odval", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("edge r%0d c%0d", e.row, e.col), 32'(oEDGE), e.edge_v);
                check($sformatf("latency r%0d c%0d", e.row, e.col), cyc, e.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        m_col = 0; m_row = 0;
        iRST_N = 1'b0; iSOF = 1'b0; iDVAL = 1'b0; iGRAY = '0;
        iMODE = 1'b0; iTHRESH = '0;
        cur_mode = 0; cur_thresh = 0;
        repeat (3) @(posedge iCLK);
        #1;
        check("reset_odval", 32'(oDVAL), 0);
        check("reset_oedge", 32'(oEDGE), 0);
        iRST_N = 1'b1;
        idle(2);

        // Flat field
        for (int i = 0; i < 3 * H; i++) drive_pix(512, i == 0);
        idle(6);

        // Vertical step
        for (int i = 0; i < 3 * H; i++) drive_pix(((i % H) < 320) ? 0 : 1023, i == 0);
        idle(6);

        // Binary threshold at and just above s=40
        iMODE = 1'b1; cur_mode = 1;
        iTHRESH = 10'd40; cur_thresh = 40;
        for (int i = 0; i < 3 * H; i++) drive_pix(((i % H) < 320) ? 0 : 40, i == 0);
        idle(6);
        iTHRESH = 10'd41; cur_thresh = 41;
        for (int i = 0; i < 3 * H; i++) drive_pix(((i % H) < 320) ? 0 : 40, i == 0);
        idle(6);
        iMODE = 1'b0; cur_mode = 0;

        // Gapped valid, one pixel every third clock
        for (int i = 0; i < 3 * H; i++) begin
            drive_pix($urandom_range(0, 1023), i == 0);
            idle(2);
        end
        idle(6);

        // Reset in mid-line discards in-flight results
        for (int i = 0; i < 200; i++) drive_pix($urandom_range(0, 1023), i == 0);
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
        iRST_N = 1'b0;
        #1;
        check("midrst_odval", 32'(oDVAL), 0);
        check("midrst_oedge", 32'(oEDGE), 0);
        sb_q.delete();
        m_col = 0; m_row = 0;
        repeat (3) @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        idle(3);
        for (int i = 0; i < 3 * H; i++) drive_pix($urandom_range(0, 1023), 1'b0);
        idle(6);

        // Start-of-frame coincident with a pixel at col 400
        for (int i = 0; i < 400; i++) drive_pix($urandom_range(0, 1023), i == 0);
        for (int i = 0; i < 3 * H; i++) drive_pix($urandom_range(0, 1023), i == 0);
        idle(8);

        check("drain_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
